// File: rtl/mult8x8_seq_ctrl.sv
`timescale 1ns/1ps
// Sequential 8x8 unsigned multiplier: four CALC cycles through one 4x4 Vedic core.
// Latency: start at edge N -> done/product after edge N+4; start is ignored while busy.

module vedic2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  logic t1, t2, t3, c1;
  always_comb begin
    t1   = x[1] & y[0];
    t2   = x[0] & y[1];
    t3   = x[1] & y[1];
    c1   = t1 & t2;
    p[0] = x[0] & y[0];
    p[1] = t1 ^ t2;
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
  end
endmodule

module vedic4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  logic [3:0] p_ll, p_hl, p_lh, p_hh;

  vedic2x2 u_ll (.x(x[1:0]), .y(y[1:0]), .p(p_ll));
  vedic2x2 u_hl (.x(x[3:2]), .y(y[1:0]), .p(p_hl));
  vedic2x2 u_lh (.x(x[1:0]), .y(y[3:2]), .p(p_lh));
  vedic2x2 u_hh (.x(x[3:2]), .y(y[3:2]), .p(p_hh));

  // Cross terms share weight 2^2; the high-high term sits at 2^4.
  always_comb begin
    p = {4'h0, p_ll} + {2'b00, p_hl, 2'b00} + {2'b00, p_lh, 2'b00} + {p_hh, 4'h0};
  end
endmodule

module mult8x8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, next_state;
  logic [1:0]  step;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic [15:0] acc_sum;
  logic        accept;

  // step[1] selects the high nibble of a, step[0] the high nibble of b.
  always_comb begin
    nib_a = step[1] ? a_q[7:4] : a_q[3:0];
    nib_b = step[0] ? b_q[7:4] : b_q[3:0];
  end

  vedic4x4 u_core (.x(nib_a), .y(nib_b), .p(pp));

  always_comb begin
    case (step)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd3:    pp_shifted = {pp, 8'h00};
      default: pp_shifted = {4'h0, pp, 4'h0};
    endcase
    acc_sum = acc + pp_shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (step == 2'd3) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc     <= 16'h0000;
      step    <= 2'd0;
      product <= 16'h0000;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= 16'h0000;
      step <= 2'd0;
    end else if (state == CALC) begin
      acc  <= acc_sum;
      step <= step + 2'd1;
      if (step == 2'd3) product <= acc_sum;
    end
  end
endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
`timescale 1ns/1ps
// Directed and randomized checks of mult8x8_seq_ctrl timing, results and reset behaviour.
module tb_mult8x8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
  int          n_chk = 0;
  int          n_pass = 0;

  mult8x8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Accept an operation, scramble inputs during CALC, then check the 4 busy cycles and the done cycle.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input bit full);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      if (full) begin
        chk({tag, "_busy"}, 16'(busy), 16'h1);
        chk({tag, "_nodone"}, 16'(done), 16'h0);
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, 16'(done), 16'h1);
    chk({tag, "_prod"}, product, exp);
    if (full) chk({tag, "_busy_lo"}, 16'(busy), 16'h0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #12;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_prod", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 16'(busy), 16'h0);

    run_op("op_12x34", 8'h12, 8'h34, 16'h03A8, 1'b1);
    @(negedge clk);
    chk("after_done", 16'(done), 16'h0);
    chk("prod_hold", product, 16'h03A8);
    run_op("op_ffxff", 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    run_op("op_00xab", 8'h00, 8'hAB, 16'h0000, 1'b1);

    // Start re-asserted during CALC with new operands must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h0F;
    @(negedge clk);
    a = 8'hFF; b = 8'h02;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", 16'(busy), 16'h1);
    @(negedge clk);
    chk("ign_done", 16'(done), 16'h1);
    chk("ign_prod", product, 16'h00E1);
    @(negedge clk);
    chk("ign_one_done", 16'(done), 16'h0);
    chk("ign_idle", 16'(busy), 16'h0);

    // Start held high: back-to-back results every 5 cycles.
    start = 1'b1; a = 8'h10; b = 8'h10;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("b2b_busy", 16'(busy), 16'h1);
        chk("b2b_nodone", 16'(done), 16'h0);
      end
      @(negedge clk);
      chk("b2b_done", 16'(done), 16'h1);
      chk("b2b_busy_lo", 16'(busy), 16'h0);
      chk("b2b_prod", product, 16'h0100);
    end
    start = 1'b0;
    @(negedge clk);

    // Reset during step2 of 0x80*0x80 aborts; outputs clear without a clock edge.
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_done", 16'(done), 16'h0);
    chk("arst_prod", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_nodone", 16'(done), 16'h0);
    end
    run_op("op_80x80", 8'h80, 8'h80, 16'h4000, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 7 == 0) ra = 8'h00;
      if (i % 7 == 1) ra = 8'hFF;
      if (i % 5 == 0) rb = 8'hFF;
      if (i % 5 == 1) rb = 8'h00;
      run_op("rand", ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
